// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm controller slice.
package alarm_pkg;

    localparam int unsigned MIN_U_W  = 4;
    localparam int unsigned MIN_Z_W  = 3;
    localparam int unsigned HOUR_U_W = 4;
    localparam int unsigned HOUR_Z_W = 2;

    localparam logic [MIN_U_W-1:0]  MIN_U_MAX        = 4'd9;
    localparam logic [MIN_Z_W-1:0]  MIN_Z_MAX        = 3'd5;
    localparam logic [HOUR_U_W-1:0] HOUR_U_MAX       = 4'd9;
    localparam logic [HOUR_Z_W-1:0] HOUR_Z_MAX       = 2'd2;
    localparam logic [HOUR_U_W-1:0] HOUR_U_MAX_AT_20 = 4'd3;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    // True when the digits form a legal 24 h time (00:00 .. 23:59).
    function automatic logic bcd_time_valid(
        input logic [HOUR_Z_W-1:0] zh,
        input logic [HOUR_U_W-1:0] uh,
        input logic [MIN_Z_W-1:0]  zm,
        input logic [MIN_U_W-1:0]  um
    );
        return (zh <= HOUR_Z_MAX) && (uh <= HOUR_U_MAX) &&
               ((zh != HOUR_Z_MAX) || (uh <= HOUR_U_MAX_AT_20)) &&
               (zm <= MIN_Z_MAX) && (um <= MIN_U_MAX);
    endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// Alarm time storage: validates set requests, flags rejects, compares against current time.
module alarm_time_reg
    import alarm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set,
    input  logic [MIN_U_W-1:0]  i_u_min_set,
    input  logic [MIN_Z_W-1:0]  i_z_min_set,
    input  logic [HOUR_U_W-1:0] i_u_hour_set,
    input  logic [HOUR_Z_W-1:0] i_z_hour_set,
    input  logic [MIN_U_W-1:0]  i_u_min,
    input  logic [MIN_Z_W-1:0]  i_z_min,
    input  logic [HOUR_U_W-1:0] i_u_hour,
    input  logic [HOUR_Z_W-1:0] i_z_hour,
    output logic [MIN_U_W-1:0]  o_u_min_alm,
    output logic [MIN_Z_W-1:0]  o_z_min_alm,
    output logic [HOUR_U_W-1:0] o_u_hour_alm,
    output logic [HOUR_Z_W-1:0] o_z_hour_alm,
    output logic                o_valid_load,
    output logic                o_set_err,
    output logic                o_match
);

    logic [MIN_U_W-1:0]  r_u_min;
    logic [MIN_Z_W-1:0]  r_z_min;
    logic [HOUR_U_W-1:0] r_u_hour;
    logic [HOUR_Z_W-1:0] r_z_hour;
    logic                r_set_err;
    logic                w_valid;

    assign w_valid = bcd_time_valid(i_z_hour_set, i_u_hour_set, i_z_min_set, i_u_min_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u_min   <= '0;
            r_z_min   <= '0;
            r_u_hour  <= '0;
            r_z_hour  <= '0;
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= i_set && !w_valid;
            if (i_set && w_valid) begin
                r_u_min  <= i_u_min_set;
                r_z_min  <= i_z_min_set;
                r_u_hour <= i_u_hour_set;
                r_z_hour <= i_z_hour_set;
            end
        end
    end

    assign o_valid_load = i_set && w_valid;
    assign o_set_err    = r_set_err;
    assign o_match      = (i_u_min == r_u_min) && (i_z_min == r_z_min) &&
                          (i_u_hour == r_u_hour) && (i_z_hour == r_z_hour);
    assign o_u_min_alm  = r_u_min;
    assign o_z_min_alm  = r_z_min;
    assign o_u_hour_alm = r_u_hour;
    assign o_z_hour_alm = r_z_hour;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm ring/snooze state machine with minute-based snooze and ring timeout.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN       = 5,
    parameter int unsigned RING_TIMEOUT_MIN = 10,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_min,
    input  logic [MIN_U_W-1:0]  u_min,
    input  logic [MIN_Z_W-1:0]  z_min,
    input  logic [HOUR_U_W-1:0] u_hour,
    input  logic [HOUR_Z_W-1:0] z_hour,
    input  logic                alarm_on,
    input  logic                set_alarm,
    input  logic [MIN_U_W-1:0]  u_min_set,
    input  logic [MIN_Z_W-1:0]  z_min_set,
    input  logic [HOUR_U_W-1:0] u_hour_set,
    input  logic [HOUR_Z_W-1:0] z_hour_set,
    input  logic                btn_snooze,
    input  logic                btn_stop,
    output logic                ring,
    output logic                snoozing,
    output logic [MIN_U_W-1:0]  u_min_alm,
    output logic [MIN_Z_W-1:0]  z_min_alm,
    output logic [HOUR_U_W-1:0] u_hour_alm,
    output logic [HOUR_Z_W-1:0] z_hour_alm,
    output logic                set_err
);

    localparam logic [3:0] LP_SNOOZE_MIN = 4'(SNOOZE_MIN);
    localparam logic [3:0] LP_RING_TO    = 4'(RING_TIMEOUT_MIN);
    localparam logic [2:0] LP_MAX_SNZ    = 3'(MAX_SNOOZE);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_min_cnt;
    logic [3:0] w_min_nxt;
    logic [3:0] w_min_inc;
    logic [2:0] r_snz_cnt;
    logic [2:0] w_snz_nxt;
    logic       r_tick_d;
    logic       r_ring;
    logic       r_snoozing;
    logic       w_valid_load;
    logic       w_match;
    logic       w_hit;

    alarm_time_reg u_time_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set        (set_alarm),
        .i_u_min_set  (u_min_set),
        .i_z_min_set  (z_min_set),
        .i_u_hour_set (u_hour_set),
        .i_z_hour_set (z_hour_set),
        .i_u_min      (u_min),
        .i_z_min      (z_min),
        .i_u_hour     (u_hour),
        .i_z_hour     (z_hour),
        .o_u_min_alm  (u_min_alm),
        .o_z_min_alm  (z_min_alm),
        .o_u_hour_alm (u_hour_alm),
        .o_z_hour_alm (z_hour_alm),
        .o_valid_load (w_valid_load),
        .o_set_err    (set_err),
        .o_match      (w_match)
    );

    // Delayed tick sees the time counter after its increment; a plain load never hits.
    assign w_hit     = r_tick_d && w_match;
    assign w_min_inc = (r_min_cnt == 4'hF) ? r_min_cnt : r_min_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min_cnt;
        w_snz_nxt   = r_snz_cnt;
        if (r_state == OFF) begin
            if (alarm_on) w_state_nxt = ARMED;
        end else if (!alarm_on) begin
            w_state_nxt = OFF;
            w_min_nxt   = '0;
            w_snz_nxt   = '0;
        end else if (w_valid_load) begin
            if (r_state == RINGING || r_state == SNOOZE) begin
                w_state_nxt = ARMED;
                w_snz_nxt   = '0;
            end
        end else begin
            unique case (r_state)
                ARMED: begin
                    if (!btn_stop && !btn_snooze && !tick_min && w_hit) begin
                        w_state_nxt = RINGING;
                        w_min_nxt   = '0;
                        w_snz_nxt   = '0;
                    end
                end
                RINGING: begin
                    if (btn_stop) begin
                        w_state_nxt = ARMED;
                    end else if (btn_snooze && (r_snz_cnt < LP_MAX_SNZ)) begin
                        w_state_nxt = SNOOZE;
                        w_snz_nxt   = r_snz_cnt + 3'd1;
                        w_min_nxt   = '0;
                    end else if (tick_min) begin
                        w_min_nxt = w_min_inc;
                        if (w_min_inc == LP_RING_TO) w_state_nxt = ARMED;
                    end
                end
                SNOOZE: begin
                    if (btn_stop) begin
                        w_state_nxt = ARMED;
                    end else if (tick_min) begin
                        w_min_nxt = w_min_inc;
                        if (w_min_inc == LP_SNOOZE_MIN) begin
                            w_state_nxt = RINGING;
                            w_min_nxt   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= OFF;
            r_min_cnt  <= '0;
            r_snz_cnt  <= '0;
            r_tick_d   <= 1'b0;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_min_cnt  <= w_min_nxt;
            r_snz_cnt  <= w_snz_nxt;
            r_tick_d   <= tick_min;
            r_ring     <= (w_state_nxt == RINGING);
            r_snoozing <= (w_state_nxt == SNOOZE);
        end
    end

    assign ring     = r_ring;
    assign snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: set-alarm vector table plus ring/snooze/timeout sequences.
module tb_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_min;
    logic [3:0] u_min;
    logic [2:0] z_min;
    logic [3:0] u_hour;
    logic [1:0] z_hour;
    logic       alarm_on;
    logic       set_alarm;
    logic [3:0] u_min_set;
    logic [2:0] z_min_set;
    logic [3:0] u_hour_set;
    logic [1:0] z_hour_set;
    logic       btn_snooze;
    logic       btn_stop;
    logic       ring;
    logic       snoozing;
    logic [3:0] u_min_alm;
    logic [2:0] z_min_alm;
    logic [3:0] u_hour_alm;
    logic [1:0] z_hour_alm;
    logic       set_err;

    alarm_ctrl #(
        .SNOOZE_MIN       (5),
        .RING_TIMEOUT_MIN (10),
        .MAX_SNOOZE       (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_min   (tick_min),
        .u_min      (u_min),
        .z_min      (z_min),
        .u_hour     (u_hour),
        .z_hour     (z_hour),
        .alarm_on   (alarm_on),
        .set_alarm  (set_alarm),
        .u_min_set  (u_min_set),
        .z_min_set  (z_min_set),
        .u_hour_set (u_hour_set),
        .z_hour_set (z_hour_set),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .ring       (ring),
        .snoozing   (snoozing),
        .u_min_alm  (u_min_alm),
        .z_min_alm  (z_min_alm),
        .u_hour_alm (u_hour_alm),
        .z_hour_alm (z_hour_alm),
        .set_err    (set_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  zh;
        logic [3:0]  uh;
        logic [2:0]  zm;
        logic [3:0]  um;
        logic        err;
        logic [12:0] alm;
    } set_vec_t;

    set_vec_t vecs[10];
    int n_vec = 0;
    int n_err = 0;
    int hh = 0;
    int mm = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_time();
        u_min  = 4'(mm % 10);
        z_min  = 3'(mm / 10);
        u_hour = 4'(hh % 10);
        z_hour = 2'(hh / 10);
    endtask

    task automatic advance_time();
        mm++;
        if (mm == 60) begin
            mm = 0;
            hh++;
            if (hh == 24) hh = 0;
        end
        drive_time();
    endtask

    // Time counter behaviour: digits change on the cycle after the tick pulse.
    task automatic tick_once();
        tick_min = 1'b1;
        step();
        tick_min = 1'b0;
        advance_time();
        step();
    endtask

    function automatic logic [12:0] alm_rb();
        return {z_hour_alm, u_hour_alm, z_min_alm, u_min_alm};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 4'd7,  3'd3, 4'd0,  1'b0, {2'd0, 4'd7, 3'd3, 4'd0}};
        vecs[1] = '{2'd2, 4'd4,  3'd0, 4'd0,  1'b1, {2'd0, 4'd7, 3'd3, 4'd0}};
        vecs[2] = '{2'd1, 4'd2,  3'd6, 4'd0,  1'b1, {2'd0, 4'd7, 3'd3, 4'd0}};
        vecs[3] = '{2'd2, 4'd3,  3'd5, 4'd9,  1'b0, {2'd2, 4'd3, 3'd5, 4'd9}};
        vecs[4] = '{2'd3, 4'd0,  3'd0, 4'd0,  1'b1, {2'd2, 4'd3, 3'd5, 4'd9}};
        vecs[5] = '{2'd1, 4'd9,  3'd5, 4'd9,  1'b0, {2'd1, 4'd9, 3'd5, 4'd9}};
        vecs[6] = '{2'd0, 4'd10, 3'd0, 4'd0,  1'b1, {2'd1, 4'd9, 3'd5, 4'd9}};
        vecs[7] = '{2'd0, 4'd0,  3'd0, 4'd10, 1'b1, {2'd1, 4'd9, 3'd5, 4'd9}};
        vecs[8] = '{2'd2, 4'd0,  3'd0, 4'd0,  1'b0, {2'd2, 4'd0, 3'd0, 4'd0}};
        vecs[9] = '{2'd0, 4'd7,  3'd3, 4'd0,  1'b0, {2'd0, 4'd7, 3'd3, 4'd0}};

        rst_n = 1'b0; tick_min = 1'b0; alarm_on = 1'b0; set_alarm = 1'b0;
        btn_snooze = 1'b0; btn_stop = 1'b0;
        u_min_set = '0; z_min_set = '0; u_hour_set = '0; z_hour_set = '0;
        hh = 0; mm = 0; drive_time();
        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset_ring", 16'(ring), 16'd0);
        chk("reset_snoozing", 16'(snoozing), 16'd0);
        chk("reset_set_err", 16'(set_err), 16'd0);
        chk("reset_alarm", 16'(alm_rb()), 16'd0);

        // Set-alarm validation table, applied while OFF.
        for (int i = 0; i < 10; i++) begin
            z_hour_set = vecs[i].zh; u_hour_set = vecs[i].uh;
            z_min_set  = vecs[i].zm; u_min_set  = vecs[i].um;
            set_alarm  = 1'b1;
            step();
            set_alarm  = 1'b0;
            chk($sformatf("set_err_v%0d", i), 16'(set_err), 16'(vecs[i].err));
            chk($sformatf("alarm_v%0d", i), 16'(alm_rb()), 16'(vecs[i].alm));
            step();
            chk($sformatf("set_err_drop_v%0d", i), 16'(set_err), 16'd0);
        end

        // Arm, then tick 07:29 -> 07:30: ring two cycles after the tick.
        alarm_on = 1'b1;
        hh = 7; mm = 29; drive_time();
        step(); step();
        chk("armed_no_ring", 16'(ring), 16'd0);
        tick_min = 1'b1;
        step();
        tick_min = 1'b0;
        advance_time();
        chk("hit_ring_lat1", 16'(ring), 16'd0);
        step();
        chk("hit_ring_lat2", 16'(ring), 16'd1);

        // Three accepted snoozes of five minutes each.
        for (int k = 0; k < 3; k++) begin
            btn_snooze = 1'b1;
            step();
            btn_snooze = 1'b0;
            chk($sformatf("snz%0d_ring", k), 16'(ring), 16'd0);
            chk($sformatf("snz%0d_snoozing", k), 16'(snoozing), 16'd1);
            for (int t = 0; t < 4; t++) tick_once();
            chk($sformatf("snz%0d_still", k), 16'(ring), 16'd0);
            tick_once();
            chk($sformatf("snz%0d_resume_ring", k), 16'(ring), 16'd1);
            chk($sformatf("snz%0d_resume_snz", k), 16'(snoozing), 16'd0);
        end
        btn_snooze = 1'b1;
        step();
        btn_snooze = 1'b0;
        chk("snz_limit_ring", 16'(ring), 16'd1);
        chk("snz_limit_snoozing", 16'(snoozing), 16'd0);

        // Auto-stop after ten ringing minutes.
        for (int t = 0; t < 9; t++) tick_once();
        chk("timeout_before", 16'(ring), 16'd1);
        tick_once();
        chk("timeout_stop", 16'(ring), 16'd0);

        // Full day of ticks; the same alarm fires again at 07:30.
        for (int t = 0; t < 1440; t++) begin
            if (hh == 7 && mm == 29) break;
            tick_once();
        end
        chk("day_pre_ring", 16'(ring), 16'd0);
        tick_once();
        chk("day_ring", 16'(ring), 16'd1);

        // Stop and snooze together: stop wins.
        btn_stop = 1'b1; btn_snooze = 1'b1;
        step();
        btn_stop = 1'b0; btn_snooze = 1'b0;
        chk("stop_snz_ring", 16'(ring), 16'd0);
        chk("stop_snz_snoozing", 16'(snoozing), 16'd0);
        step();
        chk("stop_no_retrigger", 16'(ring), 16'd0);

        // Loading the time counter onto the alarm time must not ring.
        hh = 7; mm = 29; drive_time();
        step();
        hh = 7; mm = 30; drive_time();
        step(); step(); step();
        chk("load_no_ring", 16'(ring), 16'd0);

        // alarm_on dropped during SNOOZE: no ring at snooze expiry.
        hh = 7; mm = 29; drive_time();
        step();
        tick_once();
        chk("off_test_ring", 16'(ring), 16'd1);
        btn_snooze = 1'b1;
        step();
        btn_snooze = 1'b0;
        chk("off_test_snoozing", 16'(snoozing), 16'd1);
        alarm_on = 1'b0;
        step();
        chk("off_snoozing", 16'(snoozing), 16'd0);
        chk("off_ring", 16'(ring), 16'd0);
        for (int t = 0; t < 5; t++) tick_once();
        chk("off_expiry_ring", 16'(ring), 16'd0);
        alarm_on = 1'b1;
        step(); step();

        // Asynchronous reset while ringing.
        hh = 7; mm = 29; drive_time();
        step();
        tick_once();
        chk("rst_pre_ring", 16'(ring), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ring", 16'(ring), 16'd0);
        chk("rst_alarm_zero", 16'(alm_rb()), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_after_ring", 16'(ring), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
